// File: rtl/simd_batch_ctrl.sv
// Multi-batch load/run/wait/write-back sequencer that drives the ModoSIMD engine.
// Outputs are registered decodes of the next state, so they are valid in the same cycle as the state they describe.
module simd_batch_ctrl #(
    parameter int BATCH_W     = 4,
    parameter int LOAD_CYCLES = 1,
    parameter int TIMEOUT_CYC = 256,
    parameter int TMO_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BATCH_W-1:0] num_batches,
    input  logic               abort,
    input  logic               simd_valid,
    output logic               load_regs,
    output logic               run_simd,
    output logic               write_back,
    output logic [BATCH_W-1:0] batch_idx,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [1:0]         err_code
);
    localparam int                LCNT_W      = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam logic [LCNT_W-1:0] LOAD_LAST   = LCNT_W'(LOAD_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST    = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [1:0]        ERR_TIMEOUT = 2'b01;
    localparam logic [1:0]        ERR_ABORT   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_WAIT,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [BATCH_W-1:0] total_q, total_d;
    logic [BATCH_W-1:0] batch_idx_q, batch_idx_d;
    logic [LCNT_W-1:0]  load_cnt_q, load_cnt_d;
    logic [TMO_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [1:0]         err_code_d;
    logic               abortable;

    logic               load_regs_q, run_simd_q, write_back_q;
    logic               busy_q, done_q, error_q;
    logic [1:0]         err_code_q;

    assign abortable = abort && (state_q inside {S_LOAD, S_RUN, S_WAIT, S_WRITE});

    always_comb begin
        // NOTE: every _d signal gets a hold value first so no path through the case infers a latch.
        state_d     = state_q;
        total_d     = total_q;
        batch_idx_d = batch_idx_q;
        load_cnt_d  = load_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        err_code_d  = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    total_d     = num_batches;
                    batch_idx_d = '0;
                    load_cnt_d  = '0;
                    state_d     = (num_batches != '0) ? S_LOAD : S_DONE;
                end
            end
            S_LOAD: begin
                if (load_cnt_q == LOAD_LAST) begin
                    state_d = S_RUN;
                end else begin
                    load_cnt_d = load_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (simd_valid) begin
                    state_d = S_WRITE;
                end else if ((TIMEOUT_CYC != 0) && (wait_cnt_q == TMO_LAST)) begin
                    state_d    = S_ERR;
                    err_code_d = ERR_TIMEOUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_WRITE: begin
                // Equality with total - 1 keeps batch_idx from ever wrapping at the maximum count.
                if (batch_idx_q == total_q - 1'b1) begin
                    state_d = S_DONE;
                end else begin
                    batch_idx_d = batch_idx_q + 1'b1;
                    load_cnt_d  = '0;
                    state_d     = S_LOAD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: begin
                state_d     = S_IDLE;
                batch_idx_d = '0;
            end
        endcase

        if (abortable) begin
            state_d    = S_ERR;
            err_code_d = ERR_ABORT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            total_q      <= '0;
            batch_idx_q  <= '0;
            load_cnt_q   <= '0;
            wait_cnt_q   <= '0;
            load_regs_q  <= 1'b0;
            run_simd_q   <= 1'b0;
            write_back_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments make every register update from the same pre-edge values.
            state_q      <= state_d;
            total_q      <= total_d;
            batch_idx_q  <= batch_idx_d;
            load_cnt_q   <= load_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            load_regs_q  <= (state_d == S_LOAD);
            run_simd_q   <= (state_d == S_RUN);
            write_back_q <= (state_d == S_WRITE);
            busy_q       <= (state_d != S_IDLE);
            done_q       <= (state_d == S_DONE);
            error_q      <= (state_d == S_ERR);
            err_code_q   <= err_code_d;
        end
    end

    assign load_regs  = load_regs_q;
    assign run_simd   = run_simd_q;
    assign write_back = write_back_q;
    assign batch_idx  = batch_idx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_simd_batch_ctrl.sv
// Bench for simd_batch_ctrl: two instances (load length 1 and 2) checked cycle by cycle against a
// timeline of batch phases built from the batch count, per-batch completion delays and abort point.
module tb_simd_batch_ctrl;
    localparam int BATCH_W = 4;
    localparam int TMO     = 8;

    typedef enum int {PH_IDLE, PH_LOAD, PH_RUN, PH_WAIT, PH_WRITE, PH_DONE, PH_ERR} phase_e;
    typedef struct {
        phase_e             ph;
        logic [BATCH_W-1:0] idx;
        logic [1:0]         code;
    } rec_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               start       [2];
    logic               abort       [2];
    logic               simd_valid  [2];
    logic [BATCH_W-1:0] num_batches [2];
    logic               load_regs   [2];
    logic               run_simd    [2];
    logic               write_back  [2];
    logic [BATCH_W-1:0] batch_idx   [2];
    logic               busy        [2];
    logic               done        [2];
    logic               error       [2];
    logic [1:0]         err_code    [2];

    int n_vec  = 0;
    int n_miss = 0;

    rec_t               q[$];
    int                 dly[$];
    logic [BATCH_W-1:0] wb_idx[$];
    int                 n_load, n_run, n_wb, n_busy, n_done, n_errp;

    always #5 clk = ~clk;

    simd_batch_ctrl #(.BATCH_W(BATCH_W), .LOAD_CYCLES(1), .TIMEOUT_CYC(TMO), .TMO_W(16)) dut_a (
        .clk(clk), .rst(rst), .start(start[0]), .num_batches(num_batches[0]), .abort(abort[0]),
        .simd_valid(simd_valid[0]), .load_regs(load_regs[0]), .run_simd(run_simd[0]),
        .write_back(write_back[0]), .batch_idx(batch_idx[0]), .busy(busy[0]), .done(done[0]),
        .error(error[0]), .err_code(err_code[0])
    );

    simd_batch_ctrl #(.BATCH_W(BATCH_W), .LOAD_CYCLES(2), .TIMEOUT_CYC(TMO), .TMO_W(16)) dut_b (
        .clk(clk), .rst(rst), .start(start[1]), .num_batches(num_batches[1]), .abort(abort[1]),
        .simd_valid(simd_valid[1]), .load_regs(load_regs[1]), .run_simd(run_simd[1]),
        .write_back(write_back[1]), .batch_idx(batch_idx[1]), .busy(busy[1]), .done(done[1]),
        .error(error[1]), .err_code(err_code[1])
    );

    function automatic int load_cycles(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    function automatic void put(input phase_e p, input int idx, input logic [1:0] c);
        rec_t r;
        r.ph   = p;
        r.idx  = BATCH_W'(idx);
        r.code = c;
        q.push_back(r);
    endfunction

    // Nominal timeline: one entry per cycle from the start edge to the first idle cycle after it.
    function automatic void build(input int k, input int nb);
        int l;
        l = load_cycles(k);
        q.delete();
        if (nb == 0) begin
            put(PH_DONE, 0, 2'b00);
            put(PH_IDLE, 0, 2'b00);
            return;
        end
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < l; i++) put(PH_LOAD, b, 2'b00);
            put(PH_RUN, b, 2'b00);
            if (dly[b] > TMO) begin
                for (int i = 0; i < TMO; i++) put(PH_WAIT, b, 2'b00);
                put(PH_ERR, b, 2'b01);
                put(PH_IDLE, b, 2'b00);
                return;
            end
            for (int i = 0; i < dly[b]; i++) put(PH_WAIT, b, 2'b00);
            put(PH_WRITE, b, 2'b00);
        end
        put(PH_DONE, nb - 1, 2'b00);
        put(PH_IDLE, nb - 1, 2'b00);
    endfunction

    // abort_at: step index carrying abort, -1 for none, -2 for the closing idle step.
    task automatic run_scenario(input int k, input int nb, input int abort_at, input bit noise,
                                input string tag);
        int                 s;
        int                 a;
        phase_e             prev;
        logic [BATCH_W-1:0] ci;
        logic [BATCH_W+7:0] got, want;
        build(k, nb);
        a = (abort_at == -2) ? q.size() - 1 : abort_at;
        n_load = 0; n_run = 0; n_wb = 0; n_busy = 0; n_done = 0; n_errp = 0;
        wb_idx.delete();
        s = 0;
        while (s < q.size()) begin
            prev           = (s == 0) ? PH_IDLE : q[s-1].ph;
            start[k]       = (s == 0) || (noise && ($urandom_range(0, 3) == 0));
            num_batches[k] = (s == 0) ? BATCH_W'(nb) : BATCH_W'($urandom);
            simd_valid[k]  = (prev == PH_WAIT) ? (q[s].ph == PH_WRITE)
                                               : (noise && ($urandom_range(0, 1) == 1));
            abort[k]       = (s == a);
            if (abort[k] && (prev inside {PH_LOAD, PH_RUN, PH_WAIT, PH_WRITE})) begin
                ci = q[s-1].idx;
                while (q.size() > s) void'(q.pop_back());
                put(PH_ERR, int'(ci), 2'b10);
                put(PH_IDLE, int'(ci), 2'b00);
            end
            @(posedge clk);
            #1;
            want = {q[s].ph == PH_LOAD, q[s].ph == PH_RUN, q[s].ph == PH_WRITE, q[s].ph != PH_IDLE,
                    q[s].ph == PH_DONE, q[s].ph == PH_ERR,
                    (q[s].ph == PH_ERR) ? q[s].code : 2'b00, q[s].idx};
            got  = {load_regs[k], run_simd[k], write_back[k], busy[k], done[k], error[k],
                    err_code[k], batch_idx[k]};
            n_vec++;
            if (got !== want) begin
                n_miss++;
                $display("FAIL %s dut%0d step %0d {ld,run,wb,busy,done,err,code,idx}: got %b want %b",
                         tag, k, s, got, want);
            end
            n_load += int'(load_regs[k]);
            n_run  += int'(run_simd[k]);
            n_wb   += int'(write_back[k]);
            n_busy += int'(busy[k]);
            n_done += int'(done[k]);
            n_errp += int'(error[k]);
            if (write_back[k]) wb_idx.push_back(batch_idx[k]);
            @(negedge clk);
            s++;
        end
        start[k]      = 1'b0;
        abort[k]      = 1'b0;
        simd_valid[k] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            start[k] = 1'b0; abort[k] = 1'b0; simd_valid[k] = 1'b0; num_batches[k] = '0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if ({load_regs[k], run_simd[k], write_back[k], busy[k], done[k], error[k], err_code[k],
                 batch_idx[k]} !== '0) begin
                n_miss++;
                $display("FAIL reset dut%0d: outputs got %b%b%b%b%b%b %b %h want all zero", k,
                         load_regs[k], run_simd[k], write_back[k], busy[k], done[k], error[k],
                         err_code[k], batch_idx[k]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_batch();
        dly = {3};
        run_scenario(0, 1, -1, 1'b0, "single");
        n_vec++;
        if (n_load != 1 || n_run != 1 || n_wb != 1 || n_done != 1 || n_busy != 7) begin
            n_miss++;
            $display("FAIL single counts ld/run/wb/done/busy: got %0d/%0d/%0d/%0d/%0d want 1/1/1/1/7",
                     n_load, n_run, n_wb, n_done, n_busy);
        end
    endtask

    task automatic test_multi_batch();
        dly.delete();
        for (int b = 0; b < 3; b++) dly.push_back(int'($urandom_range(1, 6)));
        run_scenario(1, 3, -1, 1'b0, "multi");
        n_vec++;
        if (n_load != 6 || n_run != 3 || n_done != 1 || wb_idx.size() != 3) begin
            n_miss++;
            $display("FAIL multi counts ld/run/done/wb: got %0d/%0d/%0d/%0d want 6/3/1/3",
                     n_load, n_run, n_done, wb_idx.size());
        end else begin
            n_vec++;
            if (wb_idx[0] !== 4'd0 || wb_idx[1] !== 4'd1 || wb_idx[2] !== 4'd2 || batch_idx[1] !== 4'd2) begin
                n_miss++;
                $display("FAIL multi idx on write_back: got %0d,%0d,%0d final %0d want 0,1,2 final 2",
                         wb_idx[0], wb_idx[1], wb_idx[2], batch_idx[1]);
            end
        end
    endtask

    task automatic test_zero_batches();
        for (int k = 0; k < 2; k++) begin
            run_scenario(k, 0, -1, 1'b1, "zero");
            n_vec++;
            if (n_busy != 1 || n_done != 1 || n_load + n_run + n_wb != 0) begin
                n_miss++;
                $display("FAIL zero dut%0d busy/done/activity: got %0d/%0d/%0d want 1/1/0", k, n_busy,
                         n_done, n_load + n_run + n_wb);
            end
        end
    endtask

    task automatic test_timeout();
        dly = {3, 50};
        run_scenario(0, 2, -1, 1'b1, "timeout");
        n_vec++;
        if (n_wb != 1 || n_done != 0 || n_errp != 1) begin
            n_miss++;
            $display("FAIL timeout wb/done/err: got %0d/%0d/%0d want 1/0/1", n_wb, n_done, n_errp);
        end
        dly = {TMO};
        run_scenario(1, 1, -1, 1'b0, "tmo_edge_ok");
        dly = {TMO + 1};
        run_scenario(1, 1, -1, 1'b0, "tmo_edge_err");
        n_vec++;
        if (n_errp != 1 || n_wb != 0) begin
            n_miss++;
            $display("FAIL tmo_edge_err err/wb: got %0d/%0d want 1/0", n_errp, n_wb);
        end
    endtask

    task automatic test_abort();
        dly = {2, 3, 4, 5};
        run_scenario(1, 4, 12, 1'b0, "abort_vs_valid");
        n_vec++;
        if (n_wb != 1 || n_errp != 1 || n_done != 0) begin
            n_miss++;
            $display("FAIL abort_vs_valid wb/err/done: got %0d/%0d/%0d want 1/1/0", n_wb, n_errp, n_done);
        end
        dly = {1, 2};
        run_scenario(1, 2, 1, 1'b0, "abort_load");
        dly = {1, 1, 1};
        run_scenario(0, 3, 0, 1'b0, "abort_idle_start");
        n_vec++;
        if (n_done != 1 || n_errp != 0) begin
            n_miss++;
            $display("FAIL abort_idle_start done/err: got %0d/%0d want 1/0", n_done, n_errp);
        end
        dly = {1, 2};
        run_scenario(0, 2, -2, 1'b0, "abort_after_done");
    endtask

    task automatic test_full_count();
        dly.delete();
        for (int b = 0; b < 15; b++) dly.push_back(int'($urandom_range(1, TMO)));
        run_scenario(0, 15, -1, 1'b1, "full");
        n_vec++;
        if (n_wb != 15 || n_done != 1 || wb_idx.size() != 15) begin
            n_miss++;
            $display("FAIL full wb/done: got %0d/%0d want 15/1", n_wb, n_done);
        end
    endtask

    task automatic test_reset_midrun();
        start[1] = 1'b1;
        num_batches[1] = 4'd3;
        @(posedge clk);
        #1;
        start[1] = 1'b0;
        n_vec++;
        if (load_regs[1] !== 1'b1 || busy[1] !== 1'b1) begin
            n_miss++;
            $display("FAIL pre_rst load/busy: got %b/%b want 1/1", load_regs[1], busy[1]);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({load_regs[1], run_simd[1], write_back[1], busy[1], done[1], error[1], err_code[1],
             batch_idx[1]} !== '0) begin
            n_miss++;
            $display("FAIL mid_rst outputs: got %b%b%b%b%b%b %b %h want all zero", load_regs[1],
                     run_simd[1], write_back[1], busy[1], done[1], error[1], err_code[1], batch_idx[1]);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        dly = {2, 1};
        run_scenario(1, 2, -1, 1'b0, "post_rst");
    endtask

    task automatic test_back_to_back();
        int k, nb, a;
        for (int n = 0; n < 25; n++) begin
            k  = int'($urandom_range(0, 1));
            nb = int'($urandom_range(0, 6));
            a  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 30)) : -1;
            dly.delete();
            for (int b = 0; b < nb; b++) dly.push_back(int'($urandom_range(1, 10)));
            run_scenario(k, nb, a, 1'b1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_single_batch();
        test_multi_batch();
        test_zero_batches();
        test_timeout();
        test_abort();
        test_full_count();
        test_reset_midrun();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
